// File: rtl/csi_fw_pkg.sv
// Shared types and constants for the CSI-2 frame writer.
// States, CSI data types and error-flag bit positions.
package csi_fw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LINE,
      IN_LINE,
      DONE
   } state_t;

   localparam logic [7:0] DT_FS   = 8'h00;
   localparam logic [7:0] DT_FE   = 8'h01;
   localparam logic [7:0] DT_RAW8 = 8'h2A;

   localparam int ERR_SHORT   = 0;
   localparam int ERR_EXTRA   = 1;
   localparam int ERR_MISS_FE = 2;

endpackage

// File: rtl/csi_addr_gen.sv
// Running RAM word address for the frame writer.
// Ports: clk, reset (sync, low), load/sel, inc, next_line -> addr.
module csi_addr_gen
   import csi_fw_pkg::*;
#(
   parameter int WORDS_PER_LINE = 160,
   parameter int FRAME_WORDS    = 76800,
   parameter int ADDR_W         = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              sel,
   input  logic              inc,
   input  logic              next_line,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [ADDR_W-1:0] FW  = ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] WPL = ADDR_W'(WORDS_PER_LINE);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] next_base;

   assign next_base = line_base + WPL;

   // line_base tracks the start of the current line so a short
   // line can jump straight to the next line slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr      <= '0;
         line_base <= '0;
      end else if (load) begin
         addr      <= sel ? FW : '0;
         line_base <= sel ? FW : '0;
      end else if (next_line) begin
         addr      <= next_base;
         line_base <= next_base;
      end else if (inc) begin
         addr      <= addr + ONE;
      end
   end

endmodule

// File: rtl/csi_frame_writer.sv
// CSI-2 RAW8 frame writer into a ping-pong RAM with geometry checks.
// Ports: stream in (data/valid/FS/FE/LS), RAM write out, frame status.
module csi_frame_writer
   import csi_fw_pkg::*;
#(
   parameter int WORDS_PER_LINE  = 160,
   parameter int LINES_PER_FRAME = 480,
   parameter int ADDR_W          = 18
) (
   input  logic              mipi_clk_8,
   input  logic              reset,
   input  logic [31:0]       data_i,
   input  logic              valid_i,
   input  logic              frame_start_i,
   input  logic              frame_end_i,
   input  logic              line_start_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              buf_sel_o,
   output logic              frame_done_o,
   output logic              done_buf_o,
   output logic              frame_err_o,
   output logic [2:0]        err_flags_o
);

   localparam int FRAME_WORDS = WORDS_PER_LINE * LINES_PER_FRAME;
   localparam int WC_W = $clog2(WORDS_PER_LINE) + 1;
   localparam int LC_W = $clog2(LINES_PER_FRAME) + 1;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LINE - 1);
   localparam logic [LC_W-1:0] MAX_LINES = LC_W'(LINES_PER_FRAME);

   state_t            state;
   logic [WC_W-1:0]   word_cnt;
   logic [WC_W-1:0]   cur_wc;
   logic [LC_W-1:0]   line_cnt;
   logic [LC_W-1:0]   line_inc;
   logic [ADDR_W-1:0] addr;
   logic              ag_load;
   logic              ag_next;
   logic              ag_inc;
   logic              take;
   logic              last_word;

   assign line_inc = line_cnt + LC_W'(1);

   csi_addr_gen #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .FRAME_WORDS    (FRAME_WORDS),
      .ADDR_W         (ADDR_W)
   ) u_addr (
      .clk       (mipi_clk_8),
      .reset     (reset),
      .load      (ag_load),
      .sel       (buf_sel_o),
      .inc       (ag_inc),
      .next_line (ag_next),
      .addr      (addr)
   );

   // take: this cycle's word is written; cur_wc is its index in the line.
   always_comb begin
      ag_load = 1'b0;
      ag_next = 1'b0;
      ag_inc  = 1'b0;
      take    = 1'b0;
      cur_wc  = word_cnt;
      unique case (state)
         IDLE: ag_load = frame_start_i;
         WAIT_LINE: begin
            ag_load = frame_start_i;
            take    = !frame_start_i && !frame_end_i && line_start_i
                      && valid_i && (line_cnt != MAX_LINES);
            cur_wc  = '0;
         end
         IN_LINE: begin
            ag_load = frame_start_i;
            ag_next = !frame_start_i && !frame_end_i && line_start_i;
            take    = !frame_start_i && !frame_end_i && !line_start_i
                      && valid_i;
         end
         DONE: ;
      endcase
      last_word = take && (cur_wc == LAST_WORD);
      if (take) begin
         ag_next = last_word;
         ag_inc  = !last_word;
      end
   end

   always_ff @(posedge mipi_clk_8) begin
      if (!reset) begin
         state        <= IDLE;
         word_cnt     <= '0;
         line_cnt     <= '0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         buf_sel_o    <= 1'b0;
         frame_done_o <= 1'b0;
         done_buf_o   <= 1'b0;
         frame_err_o  <= 1'b0;
         err_flags_o  <= '0;
      end else begin
         wr_en_o <= take;
         if (take) begin
            wr_addr_o <= addr;
            wr_data_o <= data_i;
         end
         frame_done_o <= 1'b0;
         frame_err_o  <= 1'b0;
         // missing_fe is only shown for the cycle of the restart
         err_flags_o[ERR_MISS_FE] <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start_i) begin
                  state       <= WAIT_LINE;
                  line_cnt    <= '0;
                  err_flags_o <= '0;
               end
            end
            WAIT_LINE, IN_LINE: begin
               if (frame_start_i) begin
                  state       <= WAIT_LINE;
                  line_cnt    <= '0;
                  frame_err_o <= 1'b1;
                  err_flags_o <= '0;
                  err_flags_o[ERR_MISS_FE] <= 1'b1;
               end else if (frame_end_i) begin
                  if (state == IN_LINE && word_cnt != '0)
                     err_flags_o[ERR_SHORT] <= 1'b1;
                  state <= DONE;
               end else if (line_start_i) begin
                  if (state == WAIT_LINE) begin
                     if (line_cnt == MAX_LINES) begin
                        err_flags_o[ERR_EXTRA] <= 1'b1;
                     end else begin
                        word_cnt <= '0;
                        state    <= IN_LINE;
                     end
                  end else begin
                     err_flags_o[ERR_SHORT] <= 1'b1;
                     line_cnt <= line_inc;
                     word_cnt <= '0;
                     // the truncated line filled the frame: new one is extra
                     if (line_inc == MAX_LINES) begin
                        err_flags_o[ERR_EXTRA] <= 1'b1;
                        state <= WAIT_LINE;
                     end
                  end
               end
            end
            DONE: begin
               if (line_cnt == MAX_LINES && err_flags_o == '0) begin
                  frame_done_o <= 1'b1;
                  done_buf_o   <= buf_sel_o;
                  buf_sel_o    <= ~buf_sel_o;
               end else begin
                  frame_err_o  <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (take) begin
            word_cnt <= cur_wc + WC_W'(1);
            if (last_word) begin
               line_cnt <= line_inc;
               state    <= WAIT_LINE;
            end else begin
               state    <= IN_LINE;
            end
         end
      end
   end

endmodule

// File: doc/csi_frame_writer.md
Name: csi_frame_writer

Overview:
- Downstream of the CSI-2 receiver/protocol stage; runs in the receiver's byte-clock/8 (RAM) domain.
- Takes 32-bit payload words of RAW8 long packets, plus frame-start, frame-end and line-start strobes decoded from short packets and packet headers.
- Generates write address and strobe for a ping-pong (two-frame) buffer RAM, validates line and frame geometry, and hands completed good frames to the readout side.

Parameters:
- WORDS_PER_LINE, 160, 32-bit words per line (640 px RAW8 / 4).
- LINES_PER_FRAME, 480, lines per frame.
- ADDR_W, 18, RAM word-address width; must satisfy 2*WORDS_PER_LINE*LINES_PER_FRAME <= 2**ADDR_W.

Ports:
- mipi_clk_8  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- data_i  in  32  payload word.
- valid_i  in  1  data_i valid this cycle; at most one word per cycle.
- frame_start_i  in  1  one-cycle pulse, FS short packet (type 0x00).
- frame_end_i  in  1  one-cycle pulse, FE short packet (type 0x01).
- line_start_i  in  1  one-cycle pulse, accepted RAW8 long-packet header (type 0x2A).
- wr_en_o  out  1  RAM write strobe.
- wr_addr_o  out  ADDR_W  RAM word address.
- wr_data_o  out  32  RAM write data.
- buf_sel_o  out  1  buffer half currently being written.
- frame_done_o  out  1  one-cycle pulse: good frame complete.
- done_buf_o  out  1  buffer index of the last good frame; held until the next good frame.
- frame_err_o  out  1  one-cycle pulse: frame discarded.
- err_flags_o  out  3  sticky per frame: [0] short_line, [1] extra_line, [2] missing_fe. Cleared on frame_start_i.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, all outputs 0, buf_sel_o=0, counters 0. Reset mid-frame abandons the frame; no done or error pulse is issued.
- Input priority within one cycle: frame_start_i > frame_end_i > line_start_i > valid_i.
- Base address: buf_sel_o*FRAME_WORDS, where FRAME_WORDS = WORDS_PER_LINE*LINES_PER_FRAME.
- Address generation is an incremental running register. No multiplier.
- IDLE:
  - frame_start_i -> WAIT_LINE; line_cnt=0; addr=base; err_flags_o=0.
  - All other inputs are ignored.
- WAIT_LINE:
  - line_start_i -> IN_LINE; word_cnt=0.
  - If valid_i is asserted in the same cycle, that word is word 0 of the line.
  - valid_i without line_start_i is dropped (no error).
  - frame_end_i -> DONE.
- IN_LINE:
  - Each valid_i: wr_en_o=1 on the next cycle, with wr_addr_o=addr and wr_data_o=data_i. Latency is exactly 1 cycle.
  - Each valid_i also increments addr and word_cnt.
  - The word with word_cnt==WORDS_PER_LINE-1 completes the line: line_cnt++ and -> WAIT_LINE.
  - line_start_i before the line completes: set short_line; line_cnt++; addr jumps to the next line start; new line begins with word_cnt=0.
  - frame_end_i: set short_line if word_cnt!=0, then -> DONE.
- Line limit:
  - When line_cnt==LINES_PER_FRAME, any further line_start_i sets extra_line.
  - That line's words are not written (wr_en_o suppressed); the state stays WAIT_LINE.
  - Writes never leave the current buffer half.
- frame_start_i in WAIT_LINE or IN_LINE:
  - Set missing_fe, then pulse frame_err_o on the next cycle.
  - The frame restarts into the same buffer: line_cnt=0, addr=base.
  - err_flags_o clears except missing_fe, which stays visible for that cycle only.
- DONE (one cycle):
  - Good frame (line_cnt==LINES_PER_FRAME and err_flags_o==0): frame_done_o=1, done_buf_o=buf_sel_o, buf_sel_o toggles.
  - Otherwise: frame_err_o=1 and buf_sel_o is unchanged, so the bad frame is overwritten.
  - Then -> IDLE.
- A pending wr_en_o for the final word always issues before the toggle takes effect.
- Counter widths: word_cnt $clog2(WORDS_PER_LINE)+1, line_cnt $clog2(LINES_PER_FRAME)+1. No wrap-around inside a frame.

Decomposition:
- Package csi_fw_pkg:
  - state enum IDLE/WAIT_LINE/IN_LINE/DONE;
  - data-type constants DT_FS=0x00, DT_FE=0x01, DT_RAW8=0x2A;
  - err_flags bit indices.
- Sub-module csi_addr_gen holds the running address register and the line-base register. Operations: load base, increment, jump to next line.
- The FSM, counters and write-output register stay in csi_frame_writer.

Test Plan (bench params WORDS_PER_LINE=4, LINES_PER_FRAME=3, ADDR_W=5):
1. FS, 3 lines x 4 words (0x11110000+n), FE -> 12 writes at addresses 0..11, one cycle after each valid_i; frame_done_o pulse, done_buf_o=0, buf_sel_o=1.
2. Second good frame -> writes at 12..23; done_buf_o=1; buf_sel_o back to 0.
3. Line 1 with only 2 words, then line_start_i -> short_line set; line 2 writes start at 8; FE -> frame_err_o pulse; buf_sel_o unchanged.
4. 4 lines in one frame -> 4th line: no wr_en_o, extra_line=1; FE -> frame_err_o; last write address 11.
5. FS mid-line 1 (no FE) -> missing_fe set, frame_err_o pulse; writes restart at base 0.
6. reset=0 asserted for 1 cycle during line 2 -> next cycle all outputs 0, buf_sel_o=0, no pulses; a following FS frame writes from 0.
